jpeg_huffman_decoder: RTL and testbench



---
 rtl/jpeg_huffman_decoder.sv | 187 ++++++++++++++++++
 tb/tb_jpeg_huffman_decoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/jpeg_huffman_decoder.sv
// Canonical JPEG Huffman decoder: builds mincode/maxcode/valptr from DHT counts,
// then decodes a serial MSB-first bitstream one bit per cycle into 8-bit symbols.
module jpeg_huffman_decoder #(
  parameter int MAX_LEN  = 16,
  parameter int MAX_SYMS = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cnt_we,
  input  logic [3:0] cnt_addr,
  input  logic [7:0] cnt_wdata,
  input  logic       val_we,
  input  logic [7:0] val_addr,
  input  logic [7:0] val_wdata,
  input  logic       build_start,
  output logic       table_ready,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       bit_ready,
  output logic       sym_valid,
  output logic [7:0] sym_out,
  output logic [4:0] sym_len,
  input  logic       sym_ready,
  input  logic       dec_clear,
  output logic       err
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUILD = 3'd1;
  localparam logic [2:0] S_DEC   = 3'd2;
  localparam logic [2:0] S_LOOK  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]  state;
  logic [7:0]  cnt_tbl [MAX_LEN];
  logic [7:0]  val_ram [MAX_SYMS];
  logic [7:0]  min_tbl [MAX_LEN];   // only the low byte matters for the index offset
  logic [16:0] max_tbl [MAX_LEN];
  logic [7:0]  ptr_tbl [MAX_LEN];
  logic [MAX_LEN-1:0] len_ok;

  logic [17:0] code;
  logic [8:0]  ptr;
  logic [4:0]  bl;
  logic [15:0] acc;
  logic [4:0]  len;
  logic [7:0]  idx;
  logic [4:0]  hit_len;
  logic        look_ph;
  logic [7:0]  rd_q;

  // build datapath
  logic [3:0]  bi;
  logic [7:0]  cur;
  logic [17:0] sum;
  logic [8:0]  ptr_n;
  logic        bld_bad;

  assign bi      = bl[3:0] - 4'd1;
  assign cur     = cnt_tbl[bi];
  assign sum     = code + {10'd0, cur};
  assign ptr_n   = ptr + {1'b0, cur};
  assign bld_bad = (sum > (18'd1 << bl)) || ({1'b0, ptr_n} > 10'(MAX_SYMS));

  // decode datapath: table slot for length len+1 is len[3:0]
  logic [16:0] c;
  logic [4:0]  l;
  logic [3:0]  di;
  logic        hit;
  logic [7:0]  ix;

  assign c   = {acc, bit_in};
  assign l   = len + 5'd1;
  assign di  = len[3:0];
  assign hit = len_ok[di] && (c <= max_tbl[di]);
  assign ix  = ptr_tbl[di] + c[7:0] - min_tbl[di];

  assign bit_ready = (state == S_DEC);
  assign sym_valid = (state == S_OUT);

  always_ff @(posedge clk) begin
    if (state == S_IDLE && val_we) val_ram[val_addr] <= val_wdata;
    rd_q <= val_ram[idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      for (int i = 0; i < MAX_LEN; i++) begin
        cnt_tbl[i] <= '0;
        min_tbl[i] <= '0;
        max_tbl[i] <= '0;
        ptr_tbl[i] <= '0;
      end
      len_ok      <= '0;
      code        <= '0;
      ptr         <= '0;
      bl          <= 5'd1;
      acc         <= '0;
      len         <= '0;
      idx         <= '0;
      hit_len     <= '0;
      look_ph     <= 1'b0;
      sym_out     <= '0;
      sym_len     <= '0;
      table_ready <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (state == S_IDLE && cnt_we) cnt_tbl[cnt_addr] <= cnt_wdata;
      if (build_start && state != S_BUILD) begin
        state       <= S_BUILD;
        code        <= '0;
        ptr         <= '0;
        bl          <= 5'd1;
        len_ok      <= '0;
        err         <= 1'b0;
        table_ready <= 1'b0;
      end else begin
        case (state)
          S_BUILD: begin
            if (bld_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              len_ok[bi]  <= (cur != 8'd0);
              min_tbl[bi] <= code[7:0];
              max_tbl[bi] <= sum[16:0] - 17'd1;
              ptr_tbl[bi] <= ptr[7:0];
              ptr         <= ptr_n;
              code        <= {sum[16:0], 1'b0};
              if (bl == 5'd16) begin
                state       <= S_DEC;
                table_ready <= 1'b1;
                acc         <= '0;
                len         <= '0;
              end else begin
                bl <= bl + 5'd1;
              end
            end
          end
          S_DEC: begin
            if (dec_clear) begin
              acc <= '0;
              len <= '0;
            end else if (bit_valid) begin
              if (hit) begin
                idx     <= ix;
                hit_len <= l;
                look_ph <= 1'b0;
                state   <= S_LOOK;
              end else if (l == 5'd16) begin
                state       <= S_ERR;
                err         <= 1'b1;
                table_ready <= 1'b0;
              end else begin
                acc <= c[15:0];
                len <= l;
              end
            end
          end
          S_LOOK: begin
            // phase 0 reads the RAM into rd_q, phase 1 registers the result
            if (dec_clear) begin
              state <= S_DEC;
              acc   <= '0;
              len   <= '0;
            end else if (!look_ph) begin
              look_ph <= 1'b1;
            end else begin
              sym_out <= rd_q;
              sym_len <= hit_len;
              state   <= S_OUT;
            end
          end
          S_OUT: begin
            if (dec_clear || sym_ready) begin
              state <= S_DEC;
              acc   <= '0;
              len   <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_jpeg_huffman_decoder.sv
// Directed bench for jpeg_huffman_decoder using the JPEG DC luminance table.
module tb_jpeg_huffman_decoder;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       cnt_we = 0, val_we = 0, build_start = 0;
  logic [3:0] cnt_addr = 0;
  logic [7:0] cnt_wdata = 0, val_addr = 0, val_wdata = 0;
  logic       bit_valid = 0, bit_in = 0, sym_ready = 0, dec_clear = 0;
  logic       table_ready, bit_ready, sym_valid, err;
  logic [7:0] sym_out;
  logic [4:0] sym_len;

  jpeg_huffman_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .cnt_we(cnt_we), .cnt_addr(cnt_addr), .cnt_wdata(cnt_wdata),
    .val_we(val_we), .val_addr(val_addr), .val_wdata(val_wdata),
    .build_start(build_start), .table_ready(table_ready),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_out(sym_out), .sym_len(sym_len),
    .sym_ready(sym_ready), .dec_clear(dec_clear), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    int         nb;
    logic [15:0] bits;
    logic [7:0] idx;
    logic [4:0] len;
  } vec_t;
  vec_t vt [7];

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_dc(logic [7:0] base);
    logic [7:0] cnts [16];
    cnts = '{8'd0, 8'd1, 8'd5, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1,
             8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    for (int i = 0; i < 16; i++) begin
      cnt_we = 1; cnt_addr = 4'(i); cnt_wdata = cnts[i]; step();
    end
    cnt_we = 0;
    for (int i = 0; i < 12; i++) begin
      val_we = 1; val_addr = 8'(i); val_wdata = base + 8'(i); step();
    end
    val_we = 0;
  endtask

  task automatic do_build(string nm);
    int k = 0;
    build_start = 1; step(); build_start = 0;
    while (!table_ready && k < 40) begin step(); k++; end
    chk({nm, "_latency"}, k, 16);
    chk({nm, "_err"}, err, 0);
  endtask

  task automatic send_bit(logic b);
    bit_valid = 1; bit_in = b; step(); bit_valid = 0;
  endtask

  task automatic decode(string nm, int nb, logic [15:0] bits, logic [7:0] es,
                        logic [4:0] el, int hold);
    for (int i = nb - 1; i >= 0; i--) send_bit(bits[i]);
    step();
    chk({nm, "_vld_early"}, sym_valid, 0);
    step();
    chk({nm, "_vld"}, sym_valid, 1);
    chk({nm, "_sym"}, sym_out, es);
    chk({nm, "_len"}, sym_len, el);
    for (int i = 0; i < hold; i++) begin
      step();
      chk({nm, "_hold_vld"}, sym_valid, 1);
      chk({nm, "_hold_sym"}, sym_out, es);
      chk({nm, "_hold_len"}, sym_len, el);
      chk({nm, "_hold_brdy"}, bit_ready, 0);
    end
    sym_ready = 1; step(); sym_ready = 0;
    chk({nm, "_drop"}, sym_valid, 0);
    chk({nm, "_brdy"}, bit_ready, 1);
  endtask

  task automatic run_vectors(string nm, logic [7:0] base);
    for (int v = 0; v < 7; v++)
      decode($sformatf("%s_v%0d", nm, v), vt[v].nb, vt[v].bits,
             base + vt[v].idx, vt[v].len, 0);
  endtask

  initial begin
    vt[0] = '{2, 16'b00,        8'd0,  5'd2};
    vt[1] = '{3, 16'b011,       8'd2,  5'd3};
    vt[2] = '{9, 16'b111111110, 8'd11, 5'd9};
    vt[3] = '{3, 16'b010,       8'd1,  5'd3};
    vt[4] = '{3, 16'b110,       8'd5,  5'd3};
    vt[5] = '{4, 16'b1110,      8'd6,  5'd4};
    vt[6] = '{6, 16'b111110,    8'd8,  5'd6};

    #1;
    chk("rst_tready", table_ready, 0);
    chk("rst_brdy", bit_ready, 0);
    chk("rst_svld", sym_valid, 0);
    chk("rst_sym", sym_out, 0);
    chk("rst_len", sym_len, 0);
    chk("rst_err", err, 0);
    step(2); rst_n = 1; step();

    load_dc(8'd0);
    do_build("dc_build");
    run_vectors("dc", 8'd0);

    // partial code discarded by dec_clear
    send_bit(1); send_bit(1);
    dec_clear = 1; step(); dec_clear = 0;
    decode("clear", 2, 16'b00, 8'd0, 5'd2, 0);

    decode("stall", 2, 16'b00, 8'd0, 5'd2, 5);
    decode("after_stall", 3, 16'b011, 8'd2, 5'd3, 0);

    // sixteen ones: no code matches
    for (int i = 0; i < 15; i++) send_bit(1);
    chk("ones_err_pre", err, 0);
    send_bit(1);
    chk("ones_err", err, 1);
    chk("ones_tready", table_ready, 0);
    chk("ones_brdy", bit_ready, 0);
    do_build("rebuild");
    chk("rebuild_tready", table_ready, 1);

    // async reset mid-code
    send_bit(0); send_bit(1);
    rst_n = 0; #2;
    chk("mid_rst_tready", table_ready, 0);
    chk("mid_rst_brdy", bit_ready, 0);
    chk("mid_rst_svld", sym_valid, 0);
    chk("mid_rst_sym", sym_out, 0);
    chk("mid_rst_len", sym_len, 0);
    chk("mid_rst_err", err, 0);
    step(); rst_n = 1; step();
    do_build("empty_build");
    for (int i = 0; i < 16; i++) send_bit(0);
    chk("empty_cnt_err", err, 1);

    rst_n = 0; step(); rst_n = 1; step();
    load_dc(8'hA0);
    do_build("a0_build");
    run_vectors("a0", 8'hA0);

    // oversubscribed length 1
    rst_n = 0; step(); rst_n = 1; step();
    cnt_we = 1; cnt_addr = 0; cnt_wdata = 8'd3; step(); cnt_we = 0;
    build_start = 1; step(); build_start = 0;
    chk("over_err_pre", err, 0);
    step();
    chk("over_err", err, 1);
    begin
      int seen = 0;
      for (int i = 0; i < 20; i++) begin
        step();
        if (table_ready) seen = 1;
      end
      chk("over_tready_never", seen, 0);
    end
    chk("over_err_hold", err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
